op_done_tracker: RTL
====================

OP_DONE_TRACKER -- requirements
Module: op_done_tracker

Interface
REQ-001 The module SHALL have parameter HIT_CYCLES, default 2, meaning request-to-done latency for read/write hits.
REQ-002 The module SHALL have parameter MISS_CYCLES, default 3, meaning request-to-done latency for misses when MISS_MODE=0.
REQ-003 The module SHALL have parameter MISS_MODE, default 0, meaning 0 = fixed miss latency and 1 = miss waits for mem_ack.
REQ-004 The module SHALL have parameter FILL_CYCLES, default 2, meaning mem_ack-to-done latency in MISS_MODE=1.
REQ-005 The module SHALL have parameter TIMEOUT_CYCLES, default 8, meaning request-to-forced-done limit in MISS_MODE=1.
REQ-006 The module SHALL have parameter PRE_DONE_LEAD, default 1, meaning how many cycles pre_done precedes done.
REQ-007 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-008 The module SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-009 The module SHALL have ports re and we, input, 1 bit each, the read and write requests.
REQ-010 The module SHALL have port hit, input, 1 bit, the cache hit indication, valid in the request cycle.
REQ-011 The module SHALL have port mem_ack, input, 1 bit, the memory fill acknowledge (MISS_MODE=1 only).
REQ-012 The module SHALL have port accept, output, 1 bit, high when a request is captured this cycle.
REQ-013 The module SHALL have port op_in_progress, output, 1 bit, high while an operation is outstanding.
REQ-014 The module SHALL have ports pre_done and done, output, 1 bit each, the early and final completion pulses.
REQ-015 The module SHALL have port done_op, output, 2 bits (op_t), the type of the completing operation, valid while done=1.
REQ-016 The module SHALL have port timeout, output, 1 bit, high with done when a miss hit the timeout limit.
REQ-017 The module SHALL have port conflict, output, 1 bit, a one-cycle pulse when re and we are both high in an accepted request.

Function
REQ-018 Request cycle: the state is IDLE and (re|we)=1; accept=1 combinationally in that cycle; re/we in any other state SHALL be ignored.
REQ-019 hit, re and we SHALL be sampled only in the request cycle; later changes on hit SHALL NOT create a second completion (no double done).
REQ-020 When re&we=1, the request SHALL be treated as a write and conflict SHALL pulse in the request cycle.
REQ-021 FSM states SHALL be IDLE, HIT_WAIT, MISS_WAIT, MEM_WAIT, FILL; IDLE->HIT_WAIT on a hit request, ->MISS_WAIT (MISS_MODE=0) or ->MEM_WAIT (MISS_MODE=1) on a miss request.
REQ-022 On a hit, done SHALL be high for exactly one cycle, HIT_CYCLES cycles after the request cycle; on a MISS_MODE=0 miss, MISS_CYCLES cycles after it.
REQ-023 In MEM_WAIT, mem_ack=1 in cycle A SHALL move the FSM to FILL, and done SHALL assert in cycle A+FILL_CYCLES; mem_ack in the request cycle or in any other state SHALL be ignored.
REQ-024 If no mem_ack arrives, done and timeout SHALL assert together exactly TIMEOUT_CYCLES after the request cycle; no pre_done SHALL precede a timeout done.
REQ-025 pre_done SHALL be a one-cycle pulse exactly PRE_DONE_LEAD cycles before every non-timeout done.
REQ-026 op_in_progress SHALL be high from the request cycle through the done cycle inclusive, and low otherwise.
REQ-027 The FSM SHALL return to IDLE after the done cycle; the earliest next request cycle is done+1.
REQ-028 A single down-counter SHALL time all waits; its width SHALL be $clog2(max of all latency parameters)+1.
REQ-029 Elaboration SHALL fail unless 1 <= PRE_DONE_LEAD < min(HIT_CYCLES, MISS_CYCLES, FILL_CYCLES), all latencies >= 2, and TIMEOUT_CYCLES > FILL_CYCLES.

Reset
REQ-030 When rst=0, the state SHALL be IDLE, the counter 0, and accept, op_in_progress, pre_done, done, timeout, conflict and done_op all 0, immediately and without a clock.
REQ-031 A reset mid-operation SHALL discard the operation and produce no done after reset is released.

Structure
REQ-032 Package op_done_pkg SHALL hold the op_t enum (OP_RD_HIT, OP_RD_MISS, OP_WR_HIT, OP_WR_MISS) and the state_t enum.
REQ-033 The design SHALL be a single module with no sub-module; the counter and FSM SHALL be inline.

Verification
REQ-034 Defaults, re=1 hit=1 at cycle 0: accept@0, pre_done@1, done@2 with done_op=OP_RD_HIT, op_in_progress high for cycles 0-2.
REQ-035 Read miss at cycle 0 with hit rising at cycle 1 (MISS_MODE=0): exactly one done @3 with done_op=OP_RD_MISS, and no done @4.
REQ-036 MISS_MODE=1, we=1 hit=0 at cycle 0, mem_ack at cycle 4: pre_done@5, done@6 with done_op=OP_WR_MISS, timeout=0.
REQ-037 MISS_MODE=1 miss at cycle 0 with mem_ack never asserted: done=1 and timeout=1 @8, no pre_done at any cycle.
REQ-038 re=we=1 hit=1 at cycle 0: conflict@0, done@2 with done_op=OP_WR_HIT; re held high on cycles 1-3 yields the next accept only at cycle 3.
REQ-039 Miss at cycle 0, rst=0 at cycle 1 and released at cycle 2: all outputs 0 from cycle 1 and no done afterwards.

Source files
------------

// File: rtl/op_done_pkg.sv
// Shared types for the operation-completion tracker: operation kind and FSM state.
package op_done_pkg;

  typedef enum logic [1:0] {
    OP_RD_HIT  = 2'd0,
    OP_RD_MISS = 2'd1,
    OP_WR_HIT  = 2'd2,
    OP_WR_MISS = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HIT_WAIT  = 3'd1,
    MISS_WAIT = 3'd2,
    MEM_WAIT  = 3'd3,
    FILL      = 3'd4
  } state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_of(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/op_done_tracker.sv
// Tracks one outstanding cache operation and emits pre_done/done pulses after a
// hit, fixed-miss, memory-fill or timeout latency, all timed by one down-counter.
module op_done_tracker
  import op_done_pkg::*;
#(
  parameter int HIT_CYCLES     = 2,
  parameter int MISS_CYCLES    = 3,
  parameter int MISS_MODE      = 0,
  parameter int FILL_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int PRE_DONE_LEAD  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic re,
  input  logic we,
  input  logic hit,
  input  logic mem_ack,
  output logic accept,
  output logic op_in_progress,
  output logic pre_done,
  output logic done,
  output op_t  done_op,
  output logic timeout,
  output logic conflict
);

  localparam int MAX_LAT = max_of(max_of(HIT_CYCLES, MISS_CYCLES),
                                  max_of(FILL_CYCLES, TIMEOUT_CYCLES));
  localparam int MIN_LAT = min_of(min_of(HIT_CYCLES, MISS_CYCLES), FILL_CYCLES);
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  // Counter holds the number of cycles left until the done cycle.
  localparam logic [CNT_W-1:0] HIT_LOAD     = CNT_W'(HIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MISS_LOAD    = CNT_W'(MISS_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LOAD    = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEAD_CNT     = CNT_W'(PRE_DONE_LEAD);
  localparam logic [CNT_W-1:0] LEAD_P1      = CNT_W'(PRE_DONE_LEAD + 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  if (PRE_DONE_LEAD < 1 || PRE_DONE_LEAD >= MIN_LAT ||
      HIT_CYCLES < 2 || MISS_CYCLES < 2 || FILL_CYCLES < 2 || TIMEOUT_CYCLES < 2 ||
      TIMEOUT_CYCLES <= FILL_CYCLES) begin : g_param_check
    $error("op_done_tracker: illegal latency parameter combination");
  end

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  op_t              op_reg;
  logic             pre_done_reg;
  logic             done_reg;
  logic             timeout_reg;

  // Gated by rst so the combinational outputs also read 0 during reset.
  assign accept         = rst & (state_reg == IDLE) & (re | we);
  assign conflict       = accept & re & we;
  assign op_in_progress = accept | (state_reg != IDLE);
  assign pre_done       = pre_done_reg;
  assign done           = done_reg;
  assign timeout        = timeout_reg;
  assign done_op        = done_reg ? op_reg : OP_RD_HIT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_reg       <= OP_RD_HIT;
      pre_done_reg <= 1'b0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      pre_done_reg <= 1'b0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (re | we) begin
            op_reg <= op_t'({we, ~hit});
            if (hit) begin
              state_reg    <= HIT_WAIT;
              cnt_reg      <= HIT_LOAD;
              pre_done_reg <= (HIT_LOAD == LEAD_CNT);
            end else if (MISS_MODE == 0) begin
              state_reg    <= MISS_WAIT;
              cnt_reg      <= MISS_LOAD;
              pre_done_reg <= (MISS_LOAD == LEAD_CNT);
            end else begin
              state_reg <= MEM_WAIT;
              cnt_reg   <= TIMEOUT_LOAD;
            end
          end
        end
        HIT_WAIT, MISS_WAIT, FILL: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg      <= cnt_reg - CNT_ONE;
            done_reg     <= (cnt_reg == CNT_ONE);
            pre_done_reg <= (cnt_reg == LEAD_P1);
          end
        end
        MEM_WAIT: begin
          // An ack in the timeout done cycle itself arrives too late to matter.
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
          end else if (mem_ack) begin
            state_reg    <= FILL;
            cnt_reg      <= FILL_LOAD;
            pre_done_reg <= (FILL_LOAD == LEAD_CNT);
          end else begin
            cnt_reg     <= cnt_reg - CNT_ONE;
            done_reg    <= (cnt_reg == CNT_ONE);
            timeout_reg <= (cnt_reg == CNT_ONE);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
